// File: rtl/ifetch_pkg.sv
// Shared constants and FSM encoding for the instruction fetch stage.
package ifetch_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned INSTR_WIDTH = 32;

   localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IF_RESET,
      IF_RUN,
      IF_SQUASH
   } if_state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// First-word-fall-through prefetch FIFO with synchronous flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module ifetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty,
   output logic                     o_full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign w_pop  = i_pop && !o_empty;
   assign w_push = i_push && (!o_full || w_pop);

   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: credit-limited memory requests, FWFT prefetch buffer, redirect squash.
// Optional macro IFETCH_MISALIGN_TRAP_EN presents a flagged NOP for misaligned redirect targets.
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned     DEPTH    = 2
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_redirect_valid,
   input  logic [XLEN-1:0]        i_redirect_pc,
   output logic                   o_mem_req_valid,
   input  logic                   i_mem_req_ready,
   output logic [XLEN-1:0]        o_mem_req_addr,
   input  logic                   i_mem_rsp_valid,
   input  logic [INSTR_WIDTH-1:0] i_mem_rsp_data,
   output logic                   o_inst_valid,
   input  logic                   i_inst_ready,
   output logic [INSTR_WIDTH-1:0] o_inst,
   output logic [XLEN-1:0]        o_inst_pc
`ifdef IFETCH_MISALIGN_TRAP_EN
   ,
   output logic                   o_inst_misaligned
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   if_state_e r_state, w_state_next;

   logic [XLEN-1:0]             r_fetch_pc;
   logic [XLEN-1:0]             r_resp_pc;
   logic [XLEN-1:0]             w_redir_pc;
   logic [CW-1:0]               r_outstanding;
   logic [CW-1:0]               r_discard;
   logic [CW-1:0]               w_out_after_rsp;
   logic [CW-1:0]               w_discard_next;
   logic [CW-1:0]               w_fifo_count;
   logic [INSTR_WIDTH+XLEN-1:0] w_fifo_data;
   logic                        w_fifo_empty;
   logic                        w_fifo_full;
   logic                        w_credit;
   logic                        w_req_fire;
   logic                        w_rsp_keep;
   logic                        w_pop;
   logic                        w_fetch_blocked;

   assign w_redir_pc = i_redirect_pc & ~32'h0000_0003;

   // Credits count both in-flight requests and buffered words so the FIFO cannot overflow.
   assign w_credit = !w_fifo_full && (({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < DEPTH_C);

   assign o_mem_req_valid = !i_reset && !i_redirect_valid && (r_state != IF_RESET) &&
                            w_credit && !w_fetch_blocked;
   assign o_mem_req_addr  = r_fetch_pc;
   assign w_req_fire      = o_mem_req_valid && i_mem_req_ready;

   assign w_rsp_keep      = i_mem_rsp_valid && (r_discard == '0) && !i_redirect_valid;
   assign w_out_after_rsp = r_outstanding - CW'(i_mem_rsp_valid);
   assign w_pop           = o_inst_valid && i_inst_ready && !i_redirect_valid;

   always_comb begin
      w_state_next   = r_state;
      w_discard_next = r_discard;
      if (i_redirect_valid) begin
         w_discard_next = w_out_after_rsp;
      end else if (i_mem_rsp_valid && (r_discard != '0)) begin
         w_discard_next = r_discard - 1'b1;
      end
      unique case (r_state)
         IF_RESET:  w_state_next = IF_RUN;
         IF_RUN:    w_state_next = IF_RUN;
         IF_SQUASH: if (w_discard_next == '0) w_state_next = IF_RUN;
         default:   w_state_next = IF_RESET;
      endcase
      if (i_redirect_valid) begin
         w_state_next = (w_discard_next != '0) ? IF_SQUASH : IF_RUN;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= IF_RESET;
         r_fetch_pc    <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_outstanding <= '0;
         r_discard     <= '0;
      end else begin
         r_state       <= w_state_next;
         r_discard     <= w_discard_next;
         r_outstanding <= w_out_after_rsp + CW'(w_req_fire);
         if (i_redirect_valid) begin
            r_fetch_pc <= w_redir_pc;
            r_resp_pc  <= w_redir_pc;
         end else begin
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_rsp_keep) r_resp_pc  <= r_resp_pc + 32'd4;
         end
      end
   end

   ifetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (INSTR_WIDTH + XLEN)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_flush (i_redirect_valid),
      .i_push  (w_rsp_keep),
      .i_data  ({i_mem_rsp_data, r_resp_pc}),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_count (w_fifo_count),
      .o_empty (w_fifo_empty),
      .o_full  (w_fifo_full)
   );

`ifdef IFETCH_MISALIGN_TRAP_EN
   logic            r_trap_valid;
   logic            r_trap_halt;
   logic [XLEN-1:0] r_trap_pc;

   assign w_fetch_blocked = r_trap_halt;

   // A misaligned target halts fetch until the next redirect; the flagged NOP is shown once.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_trap_valid <= 1'b0;
         r_trap_halt  <= 1'b0;
         r_trap_pc    <= '0;
      end else if (i_redirect_valid) begin
         r_trap_valid <= (i_redirect_pc[1:0] != 2'b00);
         r_trap_halt  <= (i_redirect_pc[1:0] != 2'b00);
         r_trap_pc    <= i_redirect_pc;
      end else if (r_trap_valid && i_inst_ready) begin
         r_trap_valid <= 1'b0;
      end
   end

   always_comb begin
      o_inst_valid      = !w_fifo_empty;
      o_inst            = w_fifo_empty ? '0 : w_fifo_data[INSTR_WIDTH+XLEN-1:XLEN];
      o_inst_pc         = w_fifo_empty ? '0 : w_fifo_data[XLEN-1:0];
      o_inst_misaligned = 1'b0;
      if (r_trap_valid) begin
         o_inst_valid      = 1'b1;
         o_inst            = NOP_INSTR;
         o_inst_pc         = r_trap_pc;
         o_inst_misaligned = 1'b1;
      end
   end
`else
   assign w_fetch_blocked = 1'b0;

   always_comb begin
      o_inst_valid = !w_fifo_empty;
      o_inst       = w_fifo_empty ? '0 : w_fifo_data[INSTR_WIDTH+XLEN-1:XLEN];
      o_inst_pc    = w_fifo_empty ? '0 : w_fifo_data[XLEN-1:0];
   end
`endif

endmodule
